// File: rtl/console_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : console_pkg
//  Description : Shared definitions for the 26-bit RGB pixel stream used by
//                the timing generator, console grid engine and glyph renderer.
//                Stream layout: [0] Active, [1] VS, [2] HS, [12:3] YC,
//                [22:13] XC, [25:23] RGB.
//  Revision    : 1.0 - initial release
// ============================================================================
package console_pkg;

    localparam int STREAM_W = 26;

    // Bit positions of the stream fields
    localparam int ACTIVE  = 0;
    localparam int VS      = 1;
    localparam int HS      = 2;
    localparam int YC_LSB  = 3;
    localparam int XC_LSB  = 13;
    localparam int RGB_LSB = 23;

    localparam int COORD_W = 10;

    // Field view of the stream; bit-identical to the flat vector
    typedef struct packed {
        logic [2:0]         rgb;
        logic [COORD_W-1:0] xc;
        logic [COORD_W-1:0] yc;
        logic               hs;
        logic               vs;
        logic               active;
    } rgbstr_t;

endpackage : console_pkg
`default_nettype wire

// File: rtl/rgbstr_delay.sv
`default_nettype none
// ============================================================================
//  Module      : rgbstr_delay
//  Description : Fixed-depth shift-register delay line with asynchronous
//                active-low clear. DEPTH = 0 degenerates to a wire.
//  Ports       : px_clk  - pixel clock
//                rst_n   - asynchronous active-low reset (clears all taps)
//                i_data  - WIDTH-bit input
//                o_data  - i_data delayed DEPTH cycles
//  Revision    : 1.0 - initial release
// ============================================================================
module rgbstr_delay #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 26
) (
    input  logic             px_clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_data
);

    generate
        if (DEPTH == 0) begin : g_pass
            assign o_data = i_data;
        end else begin : g_pipe
            logic [WIDTH-1:0] r_pipe [DEPTH];

            always_ff @(posedge px_clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int i = 0; i < DEPTH; i++) begin
                        r_pipe[i] <= '0;
                    end
                end else begin
                    r_pipe[0] <= i_data;
                    for (int i = 1; i < DEPTH; i++) begin
                        r_pipe[i] <= r_pipe[i-1];
                    end
                end
            end

            assign o_data = r_pipe[DEPTH-1];
        end
    endgenerate

endmodule : rgbstr_delay
`default_nettype wire

// File: rtl/dyn_console_grid.sv
`default_nettype none
// ============================================================================
//  Module      : dyn_console_grid
//  Description : Text-console grid engine. Maps each pixel of the RGB stream
//                to a character cell, issues the VRAM address of that cell
//                (with vertical wrap-around scrolling), flags the cursor cell
//                and delays the stream to match VRAM/glyph-ROM latency.
//  Ports       : px_clk, rst_n          - clock, async active-low reset
//                RGBStr_i / RGBStr_o    - pixel stream in / delayed LAT cycles
//                addr_vram, addr_vld    - cell address, cell-in-grid (lat 1)
//                glyph_col, glyph_row   - pixel offset inside glyph (lat 1)
//                pos_x, pos_y           - cell pixel origin (lat LAT)
//                scroll_i, scroll_we    - first displayed row request
//                cursor_x, cursor_y     - cursor cell (screen coordinates)
//                cursor_hit             - current cell is cursor (lat LAT)
//  Options     : DYN_CONSOLE_CURSOR_BLINK_EN - gate cursor_hit with bit
//                BLINK_BIT of a frame counter clocked by VS rising edges.
//  Revision    : 1.0 - initial release
// ============================================================================
module dyn_console_grid
    import console_pkg::*;
#(
    parameter int GLYPH_W   = 16,
    parameter int GLYPH_H   = 16,
    parameter int COLS      = 40,
    parameter int ROWS      = 30,
    parameter int ADDR_W    = 11,
    parameter int LAT       = 2,
    parameter int X_OFFSET  = 1,
    parameter int BLINK_BIT = 4
) (
    input  logic                        px_clk,
    input  logic                        rst_n,
    input  logic [STREAM_W-1:0]         RGBStr_i,
    output logic [STREAM_W-1:0]         RGBStr_o,
    output logic [ADDR_W-1:0]           addr_vram,
    output logic                        addr_vld,
    output logic [$clog2(GLYPH_W)-1:0]  glyph_col,
    output logic [$clog2(GLYPH_H)-1:0]  glyph_row,
    output logic [9:0]                  pos_x,
    output logic [9:0]                  pos_y,
    input  logic [$clog2(ROWS)-1:0]     scroll_i,
    input  logic                        scroll_we,
    input  logic [$clog2(COLS)-1:0]     cursor_x,
    input  logic [$clog2(ROWS)-1:0]     cursor_y,
    output logic                        cursor_hit
);

    localparam int c_gw_bits = $clog2(GLYPH_W);
    localparam int c_gh_bits = $clog2(GLYPH_H);
    localparam int c_rw      = $clog2(ROWS);
    localparam int c_side_w  = 21;      // pos_x, pos_y, cursor_hit

    // Cell arithmetic is done in a comfortably wide field so that the
    // out-of-grid compares see the true column/row values.
    localparam logic [23:0]   c_cols   = 24'(COLS);
    localparam logic [23:0]   c_rows   = 24'(ROWS);
    localparam logic [c_rw:0] c_rows_s = ROWS[c_rw:0];

    // Elaboration-time guard against unsupported configurations
    generate
        if (GLYPH_W < 4 || GLYPH_W > 32 || (GLYPH_W & (GLYPH_W - 1)) != 0 ||
            GLYPH_H < 4 || GLYPH_H > 32 || (GLYPH_H & (GLYPH_H - 1)) != 0 ||
            LAT < 1 || LAT > 8 || BLINK_BIT < 0 || BLINK_BIT > 7 ||
            COLS * ROWS > (1 << ADDR_W)) begin : g_param_err
            $error("dyn_console_grid: unsupported parameter set");
        end
    endgenerate

    // ------------------------------------------------------------------
    // Stage 0: combinational cell decode
    // ------------------------------------------------------------------
    logic [9:0]  w_xc;
    logic [9:0]  w_yc;
    logic        w_vs;
    logic [23:0] w_col;
    logic [23:0] w_row;
    logic [23:0] w_sum;
    logic [23:0] w_erow;
    logic [ADDR_W-1:0] w_addr;
    logic        w_in_grid;
    logic        w_cur;
    logic        w_blink;
    logic        w_vs_rise;
    logic [9:0]  w_px;
    logic [9:0]  w_py;

    logic [c_rw-1:0] r_scroll;
    logic [c_rw-1:0] r_pend_val;
    logic            r_pend;
    logic            r_vs_prev;

    assign w_xc = RGBStr_i[XC_LSB +: 10];
    assign w_yc = RGBStr_i[YC_LSB +: 10];
    assign w_vs = RGBStr_i[VS];

    assign w_col = 24'(w_xc >> c_gw_bits);
    assign w_row = 24'(w_yc >> c_gh_bits);

    assign w_in_grid = (w_col < c_cols) && (w_row < c_rows);

    // row + scroll never exceeds 2*ROWS-2 while in grid, so a single
    // conditional subtract is enough for the wrap.
    assign w_sum  = w_row + 24'(r_scroll);
    assign w_erow = (w_sum >= c_rows) ? (w_sum - c_rows) : w_sum;
    assign w_addr = ADDR_W'(w_erow * c_cols + w_col);

    assign w_cur = w_in_grid && (w_col == 24'(cursor_x)) && (w_row == 24'(cursor_y));

    assign w_px = (w_xc & ~10'(GLYPH_W - 1)) - 10'(X_OFFSET);
    assign w_py = w_yc & ~10'(GLYPH_H - 1);

    assign w_vs_rise = w_vs & ~r_vs_prev;

    // ------------------------------------------------------------------
    // Scroll control: requests are held pending and applied only on the
    // VS rising edge so a frame is never drawn with two scroll values.
    // ------------------------------------------------------------------
    always_ff @(posedge px_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vs_prev  <= 1'b0;
            r_scroll   <= '0;
            r_pend     <= 1'b0;
            r_pend_val <= '0;
        end else begin
            r_vs_prev <= w_vs;
            if (w_vs_rise && r_pend) begin
                r_scroll <= r_pend_val;
                r_pend   <= 1'b0;
            end
            // A write on the edge cycle overrides the clear above and
            // becomes pending for the next frame.
            if (scroll_we && ({1'b0, scroll_i} < c_rows_s)) begin
                r_pend_val <= scroll_i;
                r_pend     <= 1'b1;
            end
        end
    end

`ifdef DYN_CONSOLE_CURSOR_BLINK_EN
    logic [7:0] r_frame;

    always_ff @(posedge px_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_frame <= 8'd0;
        end else if (w_vs_rise) begin
            r_frame <= r_frame + 8'd1;
        end
    end

    assign w_blink = r_frame[BLINK_BIT];
`else
    assign w_blink = 1'b1;
`endif

    // ------------------------------------------------------------------
    // Stage 1: registered address and side-band
    // ------------------------------------------------------------------
    logic [c_side_w-1:0] r_side;
    logic [c_side_w-1:0] w_side_o;

    always_ff @(posedge px_clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_vram <= '0;
            addr_vld  <= 1'b0;
            glyph_col <= '0;
            glyph_row <= '0;
            r_side    <= '0;
        end else begin
            addr_vram <= w_in_grid ? w_addr : '0;
            addr_vld  <= w_in_grid;
            glyph_col <= w_xc[c_gw_bits-1:0];
            glyph_row <= w_yc[c_gh_bits-1:0];
            r_side    <= {w_px, w_py, w_cur & w_blink};
        end
    end

    // ------------------------------------------------------------------
    // Output alignment: stream delayed LAT, side-band a further LAT-1
    // after its stage-1 register so both change on the same edge.
    // ------------------------------------------------------------------
    rgbstr_delay #(
        .DEPTH (LAT),
        .WIDTH (STREAM_W)
    ) u_stream_dly (
        .px_clk (px_clk),
        .rst_n  (rst_n),
        .i_data (RGBStr_i),
        .o_data (RGBStr_o)
    );

    rgbstr_delay #(
        .DEPTH (LAT - 1),
        .WIDTH (c_side_w)
    ) u_side_dly (
        .px_clk (px_clk),
        .rst_n  (rst_n),
        .i_data (r_side),
        .o_data (w_side_o)
    );

    assign {pos_x, pos_y, cursor_hit} = w_side_o;

endmodule : dyn_console_grid
`default_nettype wire

// File: doc/dyn_console_grid.md
Name: dyn_console_grid

Overview:
- Parametrised text-console grid engine on the 26-bit RGB pixel stream.
- Maps each screen pixel to a character cell and issues the video-RAM address for that cell.
- Provides vertical hardware scrolling with wrap-around and a cursor-cell flag.
- Delays the stream so it stays aligned with downstream VRAM/glyph-ROM latency; sits between the VGA timing generator and the glyph renderer.

Parameters:
- GLYPH_W, 16: glyph width in pixels; power of 2, range 4..32.
- GLYPH_H, 16: glyph height in pixels; power of 2, range 4..32.
- COLS, 40: text columns.
- ROWS, 30: text rows.
- ADDR_W, 11: VRAM address width; COLS*ROWS must be <= 2^ADDR_W.
- LAT, 2: cycles from RGBStr_i to RGBStr_o/pos/cursor_hit; range 1..8.
- X_OFFSET, 1: value subtracted from the cell pixel origin on pos_x, compensating renderer lead.
- BLINK_BIT, 4: frame-counter bit that gates cursor blink.

Ports:
- px_clk  in  1  pixel clock; the only clock.
- rst_n  in  1  asynchronous, active-low reset.
- RGBStr_i  in  26  stream: [0] Active, [1] VS, [2] HS, [12:3] YC, [22:13] XC, [25:23] RGB.
- RGBStr_o  out  26  RGBStr_i delayed LAT cycles.
- addr_vram  out  ADDR_W  VRAM address of the current cell.
- addr_vld  out  1  cell is inside the COLS x ROWS grid.
- glyph_col  out  log2(GLYPH_W)  pixel column inside the glyph, aligned with addr_vram.
- glyph_row  out  log2(GLYPH_H)  pixel row inside the glyph, aligned with addr_vram.
- pos_x  out  10  cell pixel origin X minus X_OFFSET, aligned with RGBStr_o.
- pos_y  out  10  cell pixel origin Y, aligned with RGBStr_o.
- scroll_i  in  RW=clog2(ROWS)  requested first displayed row.
- scroll_we  in  1  write strobe for scroll_i.
- cursor_x  in  CW=clog2(COLS)  cursor column.
- cursor_y  in  RW  cursor row, in screen rows (not scrolled).
- cursor_hit  out  1  current cell is the cursor cell, aligned with RGBStr_o.

Behaviour:
- Reset:
  - All outputs are 0.
  - Scroll register, pending scroll value/flag and frame counter are 0.
  - The delay line is cleared.
- Cell decode (stage 0, combinational on input):
  - col = XC >> log2(GLYPH_W); row = YC >> log2(GLYPH_H).
  - glyph_col = XC low bits; glyph_row = YC low bits.
- Address (registered, latency 1):
  - in_grid = (col < COLS) && (row < ROWS).
  - erow = row + scroll; if erow >= ROWS then erow -= ROWS. Single conditional subtract; no modulo operator.
  - addr_vram = erow*COLS + col, ADDR_W bits, when in_grid; otherwise 0. addr_vld = in_grid.
  - Active=0 does not suppress addr_vld; blanking is handled downstream.
- Scroll:
  - scroll_we with scroll_i < ROWS latches the value as pending and sets the pending flag.
  - scroll_we with scroll_i >= ROWS is ignored.
  - On a VS rising edge (VS=1 on this cycle, 0 on the previous), a pending value is copied to the scroll register and the pending flag clears. Scroll never changes mid-frame.
  - scroll_we on the same cycle as a VS edge: the old pending value is applied; the new value becomes pending.
- Frame counter: 8-bit, increments on each VS rising edge, wraps 255 -> 0.
- Output alignment:
  - RGBStr_o is RGBStr_i delayed LAT cycles through a shift register.
  - pos_x = (col*GLYPH_W - X_OFFSET) mod 1024; pos_y = row*GLYPH_H.
  - pos_x, pos_y and cursor_hit are computed at stage 1 and delayed a further LAT-1 cycles, so they change on the same edge as RGBStr_o.
- cursor_hit = in_grid && col == cursor_x && row == cursor_y, gated as described under Optional Feature.
- Reset mid-frame: takes effect immediately (asynchronous). Outputs restart valid LAT cycles after rst_n is released; scroll returns to 0.

Optional Feature:
- Macro: DYN_CONSOLE_CURSOR_BLINK_EN.
- Defined: cursor_hit is additionally ANDed with frame_counter[BLINK_BIT].
- Undefined: cursor_hit is steady; the frame-counter logic used only for blink is removed.

Decomposition:
- Package console_pkg:
  - stream field index constants (ACTIVE=0, VS=1, HS=2, YC_LSB=3, XC_LSB=13, RGB_LSB=23);
  - STREAM_W=26;
  - the stream typedef shared with the renderer and timing generator.
- One sub-module, rgbstr_delay (parameter DEPTH, WIDTH; async active-low reset). Used for the RGBStr_o path and for the pos/cursor side-band path.

Test Plan:
- XC=35, YC=20, scroll=0, defaults -> after 1 cycle addr_vram=42, addr_vld=1, glyph_col=3, glyph_row=4; after 2 cycles pos_x=31, pos_y=16.
- scroll_we with scroll_i=29 mid-frame -> addr unchanged until the VS rising edge. After the edge, row 1 col 2 -> addr_vram=2 (wrap); row 0 col 0 -> 1160.
- XC=640 (col 40) or YC=480 (row 30) -> addr_vld=0, addr_vram=0, cursor_hit=0.
- LAT=3 build, single-cycle pulse on RGBStr_i bit 25 -> appears on RGBStr_o exactly 3 cycles later, coincident with the matching pos_x.
- cursor=(2,1) with blink enabled -> cursor_hit at XC=35, YC=20 is 0 in frames 0-15 and 1 in frames 16-31. Without the macro it is 1 in every frame.
- rst_n pulsed low mid-line with scroll=5 -> all outputs 0 asynchronously; scroll reads 0 after release; scroll_i=30 write is ignored.
